// File: rtl/reg_list_seq_pkg.sv
// Shared types and constants for the block-transfer sequencer.
// State encodings, word stride and the PC register index.
package reg_list_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_XFER  = 3'd2,
    S_WB    = 3'd3,
    S_FIN   = 3'd4
  } state_e;

  localparam logic [31:0] WORD_BYTES = 32'd4;
  localparam logic [3:0]  PC_IDX     = 4'd15;

  typedef struct packed {
    logic [3:0]  rf_r_addr;
    logic        write_reg;
    logic [3:0]  w_addr;
    logic [31:0] w_data;
    logic        write_pc;
    logic [31:0] pc_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
  } out_t;

endpackage

// File: rtl/reg_list_seq_prio_enc16.sv
// Lowest-set-bit priority encoder over a 16-bit register mask.
// idx is 0 when the mask is empty; vld flags a non-empty mask.
module prio_enc16 (
  input  logic [15:0] mask,
  output logic [3:0]  idx,
  output logic        vld
);

  // scan from the top so the lowest set bit wins
  always_comb begin
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i]) idx = 4'(i);
    end
  end

  assign vld = |mask;

endmodule

// File: rtl/reg_list_seq.sv
// Load/store-multiple sequencer: walks a register mask in ascending
// order, one memory beat per register, with optional base writeback.
module reg_list_seq
  import reg_list_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_load,
  input  logic [15:0] reglist,
  input  logic [31:0] base_addr,
  input  logic        wb_en,
  input  logic [3:0]  rn,
  output logic [3:0]  rf_r_addr,
  input  logic [31:0] rf_rdata,
  output logic        write_reg,
  output logic [3:0]  w_addr,
  output logic [31:0] w_data,
  output logic        write_pc,
  output logic [31:0] pc_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done
);

  state_e      state, nxt;
  logic        ld, wb;
  logic [3:0]  rn_q, idx;
  logic [15:0] list, orig;
  logic [31:0] base, addr;
  logic [4:0]  count;
  logic [15:0] enc_in;
  logic [3:0]  enc_idx;
  logic        enc_vld;
  logic        ack, fin_wb;
  out_t        o_d, o_q;

  // in IDLE look at the incoming mask, afterwards at what remains
  assign enc_in = (state == S_IDLE) ? reglist : list;

  prio_enc16 u_enc (
    .mask (enc_in),
    .idx  (enc_idx),
    .vld  (enc_vld)
  );

  assign ack = (state == S_XFER) && mem_ack;

  // base is not written back if a load just overwrote it
  assign fin_wb = wb && (rn_q != PC_IDX) && !(ld && orig[rn_q]);

  // state, latched transfer context and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ld    <= 1'b0;
      wb    <= 1'b0;
      rn_q  <= 4'd0;
      idx   <= 4'd0;
      list  <= 16'd0;
      orig  <= 16'd0;
      base  <= 32'd0;
      addr  <= 32'd0;
      count <= 5'd0;
      o_q   <= '0;
    end else begin
      state <= nxt;
      o_q   <= o_d;
      if (state == S_IDLE && start) begin
        ld    <= is_load;
        list  <= reglist;
        orig  <= reglist;
        wb    <= wb_en;
        rn_q  <= rn;
        base  <= base_addr;
        addr  <= base_addr;
        count <= 5'd0;
      end
      if (nxt == S_SETUP) idx <= enc_idx;
      if (ack) begin
        list  <= list & ~(16'h1 << idx);
        addr  <= addr + WORD_BYTES;
        count <= count + 5'd1;
      end
    end
  end

  // next-state decode
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (start) nxt = enc_vld ? S_SETUP : S_FIN;
      S_SETUP: nxt = S_XFER;
      S_XFER:  if (mem_ack) nxt = S_WB;
      S_WB:    nxt = enc_vld ? S_SETUP : S_FIN;
      S_FIN:   nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // next output values, registered alongside the state
  always_comb begin
    o_d           = o_q;
    o_d.write_reg = 1'b0;
    o_d.write_pc  = 1'b0;
    o_d.mem_req   = 1'b0;
    o_d.mem_we    = 1'b0;
    o_d.busy      = (nxt != S_IDLE);
    o_d.done      = (nxt == S_FIN);
    if (nxt == S_SETUP) o_d.rf_r_addr = enc_idx;
    if (state == S_SETUP) o_d.mem_wdata = rf_rdata;
    if (nxt == S_XFER) begin
      o_d.mem_req  = 1'b1;
      o_d.mem_we   = ~ld;
      o_d.mem_addr = addr;
    end
    if (ack && ld) begin
      if (idx == PC_IDX) begin
        o_d.write_pc = 1'b1;
        o_d.pc_data  = mem_rdata;
      end else begin
        o_d.write_reg = 1'b1;
        o_d.w_addr    = idx;
        o_d.w_data    = mem_rdata;
      end
    end
    if (state == S_WB && nxt == S_FIN && fin_wb) begin
      o_d.write_reg = 1'b1;
      o_d.w_addr    = rn_q;
      o_d.w_data    = base + 32'(count) * WORD_BYTES;
    end
  end

  assign rf_r_addr = o_q.rf_r_addr;
  assign write_reg = o_q.write_reg;
  assign w_addr    = o_q.w_addr;
  assign w_data    = o_q.w_data;
  assign write_pc  = o_q.write_pc;
  assign pc_data   = o_q.pc_data;
  assign mem_req   = o_q.mem_req;
  assign mem_we    = o_q.mem_we;
  assign mem_addr  = o_q.mem_addr;
  assign mem_wdata = o_q.mem_wdata;
  assign busy      = o_q.busy;
  assign done      = o_q.done;

endmodule

// File: tb/tb_reg_list_seq.sv
// Scoreboard bench for reg_list_seq: stimulus pushes expected events,
// a negedge monitor pops and compares as the DUT produces them.
module tb_reg_list_seq;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_wd;
    int          len;
  } mem_exp_t;

  typedef struct {
    logic [3:0]  a;
    logic [31:0] d;
  } reg_exp_t;

  logic        clk, rst, start, is_load, wb_en;
  logic [15:0] reglist;
  logic [31:0] base_addr;
  logic [3:0]  rn, rf_r_addr, w_addr;
  logic [31:0] rf_rdata, w_data, pc_data;
  logic        write_reg, write_pc;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int wait_cnt = 0;
  int ack_delay = 0;
  int ack_total = 0;
  int ack_mark = 0;
  logic [31:0] rd_base = 32'd0;

  mem_exp_t    mem_q[$];
  reg_exp_t    reg_q[$];
  logic [31:0] pc_q[$];
  int          done_q[$];

  int          run = 0;
  logic [31:0] run_addr = 32'd0;
  logic        run_we = 1'b0;
  logic        unstable = 1'b0;

  reg_list_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_load   (is_load),
    .reglist   (reglist),
    .base_addr (base_addr),
    .wb_en     (wb_en),
    .rn        (rn),
    .rf_r_addr (rf_r_addr),
    .rf_rdata  (rf_rdata),
    .write_reg (write_reg),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .write_pc  (write_pc),
    .pc_data   (pc_data),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign rf_rdata  = 32'hD000_0000 | {28'd0, rf_r_addr};
  assign mem_ack   = mem_req && (wait_cnt == ack_delay);
  assign mem_rdata = rd_base + 32'(ack_total - ack_mark);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
    if (mem_req && mem_ack) ack_total <= ack_total + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // monitor: pops expectations whenever the DUT presents an event
  always @(negedge clk) begin
    mem_exp_t me;
    reg_exp_t re;
    logic [31:0] pe;
    int de;
    if (mem_req) begin
      if (run == 0) begin
        run_addr = mem_addr;
        run_we   = mem_we;
      end else if (mem_addr !== run_addr || mem_we !== run_we) begin
        unstable = 1'b1;
      end
      run++;
      if (mem_ack) begin
        if (mem_q.size() == 0) begin
          chk("mem_unexpected", 32'd1, 32'd0);
        end else begin
          me = mem_q.pop_front();
          chk("mem_we", {31'd0, mem_we}, {31'd0, me.we});
          chk("mem_addr", mem_addr, me.addr);
          if (me.chk_wd) chk("mem_wdata", mem_wdata, me.wdata);
          chk("mem_req_len", 32'(run), 32'(me.len));
          chk("mem_stable", {31'd0, unstable}, 32'd0);
        end
        run = 0;
        unstable = 1'b0;
      end
    end else begin
      run = 0;
      unstable = 1'b0;
    end
    if (write_reg || write_pc)
      chk("strobe_excl", {31'd0, write_reg & write_pc}, 32'd0);
    if (write_reg) begin
      chk("w_addr_not_pc", {31'd0, w_addr == 4'd15}, 32'd0);
      if (reg_q.size() == 0) begin
        chk("reg_unexpected", {28'd0, w_addr}, 32'hFFFF_FFFF);
      end else begin
        re = reg_q.pop_front();
        chk("w_addr", {28'd0, w_addr}, {28'd0, re.a});
        chk("w_data", w_data, re.d);
      end
    end
    if (write_pc) begin
      if (pc_q.size() == 0) begin
        chk("pc_unexpected", pc_data, 32'hFFFF_FFFF);
      end else begin
        pe = pc_q.pop_front();
        chk("pc_data", pc_data, pe);
      end
    end
    if (done) begin
      if (done_q.size() == 0) begin
        chk("done_unexpected", 32'd1, 32'd0);
      end else begin
        de = done_q.pop_front();
        chk("done_latency", 32'(cyc - start_cyc), 32'(de));
      end
    end
  end

  function automatic mem_exp_t mx(input logic we, input logic [31:0] a,
                                  input logic [31:0] d, input int len);
    mem_exp_t m;
    m.we = we;
    m.addr = a;
    m.wdata = d;
    m.chk_wd = we;
    m.len = len;
    return m;
  endfunction

  function automatic reg_exp_t rx(input logic [3:0] a,
                                  input logic [31:0] d);
    reg_exp_t r;
    r.a = a;
    r.d = d;
    return r;
  endfunction

  task automatic do_xfer(input logic ld, input logic [15:0] rl,
                         input logic [31:0] ba, input logic wbe,
                         input logic [3:0] r, input int dly,
                         input logic [31:0] rdb, input bit poke);
    int n;
    @(negedge clk);
    ack_delay = dly;
    rd_base   = rdb;
    ack_mark  = ack_total;
    is_load   = ld;
    reglist   = rl;
    base_addr = ba;
    wb_en     = wbe;
    rn        = r;
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    if (poke) begin
      @(negedge clk);
      start   = 1'b1;
      is_load = 1'b0;
      reglist = 16'hFFFF;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("idle_after_xfer", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    is_load = 1'b0;
    reglist = 16'd0;
    base_addr = 32'd0;
    wb_en = 1'b0;
    rn = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_write_reg", {31'd0, write_reg}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);

    // store R0, R2 with immediate ack
    mem_q.push_back(mx(1'b1, 32'h100, 32'hD000_0000, 1));
    mem_q.push_back(mx(1'b1, 32'h104, 32'hD000_0002, 1));
    done_q.push_back(7);
    do_xfer(1'b0, 16'h0005, 32'h100, 1'b0, 4'd0, 0, 32'd0, 1'b0);

    // load R1 and PC
    mem_q.push_back(mx(1'b0, 32'h200, 32'd0, 1));
    mem_q.push_back(mx(1'b0, 32'h204, 32'd0, 1));
    reg_q.push_back(rx(4'd1, 32'hA));
    pc_q.push_back(32'hB);
    done_q.push_back(7);
    do_xfer(1'b1, 16'h8002, 32'h200, 1'b0, 4'd0, 0, 32'hA, 1'b0);

    // load R3, R4 with base R3: base was loaded, no writeback
    mem_q.push_back(mx(1'b0, 32'h300, 32'd0, 1));
    mem_q.push_back(mx(1'b0, 32'h304, 32'd0, 1));
    reg_q.push_back(rx(4'd3, 32'h50));
    reg_q.push_back(rx(4'd4, 32'h51));
    done_q.push_back(7);
    do_xfer(1'b1, 16'h0018, 32'h300, 1'b1, 4'd3, 0, 32'h50, 1'b0);

    // same with base R5: writeback base+8 in FIN
    mem_q.push_back(mx(1'b0, 32'h300, 32'd0, 1));
    mem_q.push_back(mx(1'b0, 32'h304, 32'd0, 1));
    reg_q.push_back(rx(4'd3, 32'h50));
    reg_q.push_back(rx(4'd4, 32'h51));
    reg_q.push_back(rx(4'd5, 32'h308));
    done_q.push_back(7);
    do_xfer(1'b1, 16'h0018, 32'h300, 1'b1, 4'd5, 0, 32'h50, 1'b0);

    // store R0 with ack after 4 wait cycles, extra start while busy
    mem_q.push_back(mx(1'b1, 32'h400, 32'hD000_0000, 5));
    done_q.push_back(8);
    do_xfer(1'b0, 16'h0001, 32'h400, 1'b0, 4'd0, 4, 32'd0, 1'b1);

    // empty list: straight to FIN
    done_q.push_back(1);
    do_xfer(1'b0, 16'h0000, 32'h600, 1'b1, 4'd2, 0, 32'd0, 1'b0);

    // reset while in XFER
    @(negedge clk);
    ack_delay = 20;
    is_load = 1'b0;
    reglist = 16'h0003;
    base_addr = 32'h500;
    wb_en = 1'b1;
    rn = 4'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("xfer_before_rst", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("post_rst_done", {31'd0, done}, 32'd0);
    chk("post_rst_write_reg", {31'd0, write_reg}, 32'd0);
    repeat (6) @(negedge clk);
    chk("rst_stays_idle", {31'd0, busy}, 32'd0);

    // fresh transfer after reset
    mem_q.push_back(mx(1'b1, 32'h700, 32'hD000_0007, 1));
    reg_q.push_back(rx(4'd1, 32'h704));
    done_q.push_back(4);
    do_xfer(1'b0, 16'h0080, 32'h700, 1'b1, 4'd1, 0, 32'd0, 1'b0);

    chk("mem_q_empty", 32'(mem_q.size()), 32'd0);
    chk("reg_q_empty", 32'(reg_q.size()), 32'd0);
    chk("pc_q_empty", 32'(pc_q.size()), 32'd0);
    chk("done_q_empty", 32'(done_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
